ecpm_arbiter: RTL

Round-robin scheduler that shares one ScalarMult core (256-bit Jacobian scalar-point multiply, secp256k1 prime supplied as an input) among N_REQ requesters. The arbiter accepts one request, latches its operands, pulses the core start, and waits for core done with a watchdog. It then returns the tagged result and error code to the owning requester over a valid/ready response channel. It sits between the ECDSA/keygen clients and the ScalarMult datapath.

---
 rtl/ecpm_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ecpm_arbiter.sv
// Round-robin scheduler sharing one ScalarMult core among N_REQ requesters.
// Accepts one request, launches the core, watchdogs it, returns the tagged result.
module ecpm_arbiter #(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 256,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_p,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_k,
  input  logic [N_REQ*WIDTH-1:0] i_req_X,
  input  logic [N_REQ*WIDTH-1:0] i_req_Y,
  input  logic [N_REQ*WIDTH-1:0] i_req_Z,
  output logic [N_REQ-1:0]       o_rsp_valid,
  input  logic [N_REQ-1:0]       i_rsp_ready,
  output logic [WIDTH-1:0]       o_rsp_X,
  output logic [WIDTH-1:0]       o_rsp_Y,
  output logic [WIDTH-1:0]       o_rsp_Z,
  output logic [1:0]             o_rsp_err,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic                   o_busy,
  output logic                   o_core_start,
  output logic                   o_core_rst_n,
  output logic [WIDTH-1:0]       o_core_k,
  output logic [WIDTH-1:0]       o_core_X,
  output logic [WIDTH-1:0]       o_core_Y,
  output logic [WIDTH-1:0]       o_core_Z,
  output logic [WIDTH-1:0]       o_core_p,
  input  logic                   i_core_done,
  input  logic [WIDTH-1:0]       i_core_X,
  input  logic [WIDTH-1:0]       i_core_Y,
  input  logic [WIDTH-1:0]       i_core_Z
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_INF     = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
  localparam logic [1:0]  ERR_K_ZERO  = 2'b11;
  localparam logic [19:0] WD_LAST     = 20'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   owner;
  logic [19:0]       wd_cnt;
  logic              abort_q;
  logic [ID_W-1:0]   winner;
  logic              win_found;
  logic [WIDTH-1:0]  win_k, win_x, win_y, win_z;

  // Rotating priority: scan upward from the requester after the last grant.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found && i_req_valid[(int'(last_grant) + i) % N_REQ]) begin
        win_found = 1'b1;
        winner    = ID_W'((int'(last_grant) + i) % N_REQ);
      end
    end
  end

  assign win_k = i_req_k[int'(winner)*WIDTH +: WIDTH];
  assign win_x = i_req_X[int'(winner)*WIDTH +: WIDTH];
  assign win_y = i_req_Y[int'(winner)*WIDTH +: WIDTH];
  assign win_z = i_req_Z[int'(winner)*WIDTH +: WIDTH];

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (state == IDLE && win_found && !i_rst) o_req_ready[winner] = 1'b1;
    if (state == RESP)                        o_rsp_valid[owner]  = 1'b1;
  end

  assign o_busy       = (state != IDLE);
  assign o_rsp_id     = owner;
  assign o_core_rst_n = ~(i_rst | abort_q);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the wide operand/result registers are cleared too, so nothing from a dropped request leaks out.
      state        <= IDLE;
      last_grant   <= ID_W'(N_REQ - 1);
      owner        <= '0;
      wd_cnt       <= '0;
      abort_q      <= 1'b0;
      o_core_start <= 1'b0;
      o_core_k     <= '0;
      o_core_X     <= '0;
      o_core_Y     <= '0;
      o_core_Z     <= '0;
      o_core_p     <= '0;
      o_rsp_X      <= '0;
      o_rsp_Y      <= '0;
      o_rsp_Z      <= '0;
      o_rsp_err    <= ERR_OK;
    end else begin
      o_core_start <= 1'b0;
      abort_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            o_core_k   <= win_k;
            o_core_X   <= win_x;
            o_core_Y   <= win_y;
            o_core_Z   <= win_z;
            o_core_p   <= i_p;
            owner      <= winner;
            last_grant <= winner;
            if (win_k == '0) begin
              // k==0 is rejected without ever touching the core.
              o_rsp_X   <= '0;
              o_rsp_Y   <= '0;
              o_rsp_Z   <= '0;
              o_rsp_err <= ERR_K_ZERO;
              state     <= RESP;
            end else begin
              o_core_start <= 1'b1;
              state        <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // Done takes precedence over a coincident watchdog expiry.
          if (i_core_done) begin
            o_rsp_X   <= i_core_X;
            o_rsp_Y   <= i_core_Y;
            o_rsp_Z   <= i_core_Z;
            o_rsp_err <= (i_core_Z == '0) ? ERR_INF : ERR_OK;
            state     <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            o_rsp_X   <= '0;
            o_rsp_Y   <= '0;
            o_rsp_Z   <= '0;
            o_rsp_err <= ERR_TIMEOUT;
            abort_q   <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 20'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
